// File: rtl/cpu_pkg.sv
`default_nettype none
// ============================================================================
// Module  : cpu_pkg
// Brief   : Shared types and constants for the MIPS pipeline front end.
// Revision: 1.0 - initial release
// ============================================================================
package cpu_pkg;

    // Fetch sequencer states
    typedef enum logic [1:0] {
        FETCH = 2'd0,   // request outstanding at pc
        HOLD  = 2'd1,   // fetched word parked in the skid buffer, decode stalled
        DRAIN = 2'd2    // waiting out a stale request before jumping to pend_pc
    } fetch_state_t;

    // sll $0,$0,0
    localparam logic [31:0] c_nop_word   = 32'h0000_0000;
    localparam logic [31:0] c_pc_inc     = 32'd4;
    localparam logic [31:0] c_align_mask = 32'hFFFF_FFFC;

    // Force a byte address onto a word boundary
    function automatic logic [31:0] align_pc(input logic [31:0] pc);
        return pc & c_align_mask;
    endfunction

endpackage
`default_nettype wire

// File: rtl/if_id_reg.sv
`default_nettype none
// ============================================================================
// Module  : if_id_reg
// Brief   : IF/ID pipeline register with flush > stall > load priority.
//           An empty slot carries NOP_WORD so decode sees a harmless op.
// Revision: 1.0 - initial release
// ============================================================================
module if_id_reg #(
    parameter logic [31:0] NOP_WORD = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        i_flush,
    input  logic        i_stall,
    input  logic        i_load,
    input  logic [31:0] i_instr,
    input  logic [31:0] i_pc,
    input  logic [31:0] i_pc4,
    output logic        o_valid,
    output logic [31:0] o_instr,
    output logic [31:0] o_pc,
    output logic [31:0] o_pc4
);

    logic        r_valid;
    logic [31:0] r_instr;
    logic [31:0] r_pc;
    logic [31:0] r_pc4;

    // Slot update: squash, hold, take a new word, or insert a bubble
    always_ff @(posedge clk) begin
        if (rst) begin
            r_valid <= 1'b0;
            r_instr <= NOP_WORD;
            r_pc    <= 32'h0;
            r_pc4   <= 32'h0;
        end else if (i_flush) begin
            r_valid <= 1'b0;
            r_instr <= NOP_WORD;
        end else if (i_stall) begin
            r_valid <= r_valid;
        end else if (i_load) begin
            r_valid <= 1'b1;
            r_instr <= i_instr;
            r_pc    <= i_pc;
            r_pc4   <= i_pc4;
        end else begin
            // Bubble: pc/pc4 keep their last value so they stay deterministic
            r_valid <= 1'b0;
            r_instr <= NOP_WORD;
        end
    end

    assign o_valid = r_valid;
    assign o_instr = r_instr;
    assign o_pc    = r_pc;
    assign o_pc4   = r_pc4;

endmodule
`default_nettype wire

// File: rtl/if_stage.sv
`default_nettype none
// ============================================================================
// Module  : if_stage
// Brief   : Instruction-fetch stage. Owns the PC, runs the req/ack fetch
//           handshake (one request in flight), parks one word when decode
//           stalls, and handles branch/jump redirects and IF/ID flushes.
// Revision: 1.0 - initial release
// ============================================================================
module if_stage
    import cpu_pkg::*;
#(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter logic [31:0] NOP_WORD = c_nop_word
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        stall_i,
    input  logic        flush_i,
    input  logic        redirect_i,
    input  logic [31:0] redirect_pc_i,
    output logic        imem_req_o,
    output logic [31:0] imem_addr_o,
    input  logic        imem_ack_i,
    input  logic [31:0] imem_rdata_i,
    output logic        ifid_valid_o,
    output logic [31:0] ifid_instr_o,
    output logic [31:0] ifid_pc_o,
    output logic [31:0] ifid_pc4_o
);

    fetch_state_t r_state;
    fetch_state_t w_state_nxt;

    logic [31:0] r_pc;
    logic [31:0] w_pc_nxt;
    logic [31:0] r_pend_pc;
    logic [31:0] w_pend_pc_nxt;
    logic [31:0] r_skid_instr;
    logic [31:0] w_skid_instr_nxt;
    logic [31:0] r_skid_pc;
    logic [31:0] w_skid_pc_nxt;

    logic        w_req;
    logic        w_load;
    logic [31:0] w_load_instr;
    logic [31:0] w_load_pc;
    logic [31:0] w_load_pc4;
    logic [31:0] w_redirect_pc;
    logic [31:0] w_pc_plus4;

    assign w_redirect_pc = align_pc(redirect_pc_i);
    assign w_pc_plus4    = r_pc + c_pc_inc;
    assign w_load_pc4    = w_load_pc + c_pc_inc;

    // Fetch sequencer state, PC, pending redirect target and skid buffer
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state      <= FETCH;
            r_pc         <= RESET_PC;
            r_pend_pc    <= RESET_PC;
            r_skid_instr <= NOP_WORD;
            r_skid_pc    <= RESET_PC;
        end else begin
            r_state      <= w_state_nxt;
            r_pc         <= w_pc_nxt;
            r_pend_pc    <= w_pend_pc_nxt;
            r_skid_instr <= w_skid_instr_nxt;
            r_skid_pc    <= w_skid_pc_nxt;
        end
    end

    // Next-state, PC update and IF/ID load selection; redirect beats stall
    always_comb begin
        w_state_nxt      = r_state;
        w_pc_nxt         = r_pc;
        w_pend_pc_nxt    = r_pend_pc;
        w_skid_instr_nxt = r_skid_instr;
        w_skid_pc_nxt    = r_skid_pc;
        w_req            = 1'b0;
        w_load           = 1'b0;
        w_load_instr     = r_skid_instr;
        w_load_pc        = r_skid_pc;

        case (r_state)
            FETCH: begin
                w_req = 1'b1;
                if (imem_ack_i) begin
                    if (redirect_i) begin
                        w_pc_nxt = w_redirect_pc;
                    end else if (stall_i) begin
                        w_skid_instr_nxt = imem_rdata_i;
                        w_skid_pc_nxt    = r_pc;
                        w_state_nxt      = HOLD;
                    end else begin
                        w_load       = 1'b1;
                        w_load_instr = imem_rdata_i;
                        w_load_pc    = r_pc;
                        w_pc_nxt     = w_pc_plus4;
                    end
                end else if (redirect_i) begin
                    // Address must stay stable until ack, so park the target
                    w_pend_pc_nxt = w_redirect_pc;
                    w_state_nxt   = DRAIN;
                end
            end

            HOLD: begin
                if (redirect_i) begin
                    w_pc_nxt    = w_redirect_pc;
                    w_state_nxt = FETCH;
                end else if (!stall_i) begin
                    w_load      = 1'b1;
                    w_pc_nxt    = w_pc_plus4;
                    w_state_nxt = FETCH;
                end
            end

            DRAIN: begin
                w_req = 1'b1;
                if (redirect_i) begin
                    w_pend_pc_nxt = w_redirect_pc;
                end
                if (imem_ack_i) begin
                    // Latest redirect wins, including one arriving with the ack
                    w_pc_nxt    = redirect_i ? w_redirect_pc : r_pend_pc;
                    w_state_nxt = FETCH;
                end
            end

            default: begin
                w_state_nxt = FETCH;
            end
        endcase
    end

    assign imem_req_o  = w_req & ~rst;
    assign imem_addr_o = r_pc;

    if_id_reg #(
        .NOP_WORD (NOP_WORD)
    ) u_if_id_reg (
        .clk      (clk),
        .rst      (rst),
        .i_flush  (flush_i),
        .i_stall  (stall_i),
        .i_load   (w_load),
        .i_instr  (w_load_instr),
        .i_pc     (w_load_pc),
        .i_pc4    (w_load_pc4),
        .o_valid  (ifid_valid_o),
        .o_instr  (ifid_instr_o),
        .o_pc     (ifid_pc_o),
        .o_pc4    (ifid_pc4_o)
    );

endmodule
`default_nettype wire

// File: tb/tb_if_stage.sv
`default_nettype none
// ============================================================================
// Module  : tb_if_stage
// Brief   : Directed self-checking bench for if_stage. Memory returns the
//           fetch address as the instruction word; ack is gated by ack_en.
// Revision: 1.0 - initial release
// ============================================================================
module tb_if_stage;

    logic        clk = 1'b0;
    logic        rst;
    logic        stall_i;
    logic        flush_i;
    logic        redirect_i;
    logic [31:0] redirect_pc_i;
    logic        imem_req_o;
    logic [31:0] imem_addr_o;
    logic        imem_ack_i;
    logic [31:0] imem_rdata_i;
    logic        ifid_valid_o;
    logic [31:0] ifid_instr_o;
    logic [31:0] ifid_pc_o;
    logic [31:0] ifid_pc4_o;

    logic        ack_en;
    int          checks   = 0;
    int          failures = 0;

    always #5 clk = ~clk;

    // Memory model: data is the address, ack only while requested and enabled
    assign imem_ack_i   = ack_en & imem_req_o;
    assign imem_rdata_i = imem_addr_o;

    if_stage #(
        .RESET_PC (32'h0000_0000),
        .NOP_WORD (32'h0000_0000)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .stall_i       (stall_i),
        .flush_i       (flush_i),
        .redirect_i    (redirect_i),
        .redirect_pc_i (redirect_pc_i),
        .imem_req_o    (imem_req_o),
        .imem_addr_o   (imem_addr_o),
        .imem_ack_i    (imem_ack_i),
        .imem_rdata_i  (imem_rdata_i),
        .ifid_valid_o  (ifid_valid_o),
        .ifid_instr_o  (ifid_instr_o),
        .ifid_pc_o     (ifid_pc_o),
        .ifid_pc4_o    (ifid_pc4_o)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Advance one edge and let registered outputs settle
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        #1;
    endtask

    task automatic check_slot(input string tag, input logic v, input logic [31:0] pc);
        check({tag, ".valid"}, {31'b0, ifid_valid_o}, {31'b0, v});
        check({tag, ".instr"}, ifid_instr_o, v ? pc : 32'h0);
        if (v) begin
            check({tag, ".pc"},  ifid_pc_o,  pc);
            check({tag, ".pc4"}, ifid_pc4_o, pc + 32'd4);
        end
    endtask

    task automatic check_req(input string tag, input logic r, input logic [31:0] a);
        check({tag, ".req"}, {31'b0, imem_req_o}, {31'b0, r});
        if (r) check({tag, ".addr"}, imem_addr_o, a);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        stall_i = 1'b0; flush_i = 1'b0; redirect_i = 1'b0;
        redirect_pc_i = 32'h0; ack_en = 1'b0;
        tick();
        tick();
    endtask

    initial begin
        // ---------------- reset state ----------------
        do_reset();
        check("rst.valid", {31'b0, ifid_valid_o}, 32'd0);
        check("rst.instr", ifid_instr_o, 32'h0);
        check("rst.pc",    ifid_pc_o,    32'h0);
        check("rst.pc4",   ifid_pc4_o,   32'h0);
        check("rst.req",   {31'b0, imem_req_o}, 32'd0);

        // ---------------- zero-wait streaming ----------------
        ack_en = 1'b1; rst = 1'b0; settle();
        check_req("zw.c1", 1'b1, 32'h0);
        tick();
        check_slot("zw.e0", 1'b1, 32'h0);
        check_req("zw.e0", 1'b1, 32'h4);
        for (int k = 1; k <= 3; k++) begin
            tick();
            check_slot("zw.stream", 1'b1, 32'(4 * k));
            check_req("zw.stream", 1'b1, 32'(4 * k + 4));
        end

        // ---------------- 3-cycle ack latency ----------------
        do_reset();
        rst = 1'b0; settle();
        check_req("lat.c1", 1'b1, 32'h0);
        tick();
        check_slot("lat.c2", 1'b0, 32'h0);
        check_req("lat.c2", 1'b1, 32'h0);
        tick();
        check_slot("lat.c3", 1'b0, 32'h0);
        check_req("lat.c3", 1'b1, 32'h0);
        ack_en = 1'b1;
        tick();
        check_slot("lat.done", 1'b1, 32'h0);
        check_req("lat.done", 1'b1, 32'h4);

        // ---------------- stall into HOLD ----------------
        do_reset();
        ack_en = 1'b1; rst = 1'b0;
        tick();
        tick();
        check_slot("st.pre", 1'b1, 32'h4);
        check_req("st.pre", 1'b1, 32'h8);
        stall_i = 1'b1;
        for (int k = 0; k < 4; k++) begin
            tick();
            check_slot("st.hold", 1'b1, 32'h4);
            check_req("st.hold", 1'b0, 32'h0);
        end
        stall_i = 1'b0;
        tick();
        check_slot("st.rel", 1'b1, 32'h8);
        check_req("st.rel", 1'b1, 32'hC);

        // ---------------- redirect + flush with request pending ----------------
        do_reset();
        ack_en = 1'b1; rst = 1'b0;
        for (int k = 0; k < 4; k++) tick();
        check_slot("rd.pre", 1'b1, 32'hC);
        ack_en = 1'b0;
        tick();
        check_slot("rd.wait", 1'b0, 32'h0);
        check_req("rd.wait", 1'b1, 32'h10);
        redirect_i = 1'b1; redirect_pc_i = 32'h100; flush_i = 1'b1;
        tick();
        redirect_i = 1'b0; flush_i = 1'b0; settle();
        check_slot("rd.drain", 1'b0, 32'h0);
        check_req("rd.drain", 1'b1, 32'h10);
        tick();
        check_req("rd.drain2", 1'b1, 32'h10);
        ack_en = 1'b1;
        tick();
        check_slot("rd.disc", 1'b0, 32'h0);
        check_req("rd.new", 1'b1, 32'h100);
        tick();
        check_slot("rd.tgt", 1'b1, 32'h100);

        // ---------------- stall+flush, then stall+redirect in HOLD ----------------
        do_reset();
        ack_en = 1'b1; rst = 1'b0;
        tick();
        check_slot("sf.pre", 1'b1, 32'h0);
        stall_i = 1'b1; flush_i = 1'b1;
        tick();
        check_slot("sf.flush", 1'b0, 32'h0);
        check_req("sf.hold", 1'b0, 32'h0);
        flush_i = 1'b0; redirect_i = 1'b1; redirect_pc_i = 32'h40;
        tick();
        redirect_i = 1'b0; settle();
        check_slot("sr.held", 1'b0, 32'h0);
        check_req("sr.new", 1'b1, 32'h40);
        stall_i = 1'b0;
        tick();
        check_slot("sr.tgt", 1'b1, 32'h40);

        // ---------------- PC wrap (low address bits forced to zero) ----------------
        redirect_i = 1'b1; redirect_pc_i = 32'hFFFF_FFFF;
        tick();
        redirect_i = 1'b0; settle();
        check_slot("wr.bub", 1'b0, 32'h0);
        check_req("wr.top", 1'b1, 32'hFFFF_FFFC);
        tick();
        check_slot("wr.top", 1'b1, 32'hFFFF_FFFC);
        check("wr.pc4", ifid_pc4_o, 32'h0);
        check_req("wr.wrap", 1'b1, 32'h0);
        tick();
        tick();
        check_req("wr.run", 1'b1, 32'h8);

        // ---------------- reset in DRAIN ----------------
        ack_en = 1'b0; redirect_i = 1'b1; redirect_pc_i = 32'h200;
        tick();
        redirect_i = 1'b0; settle();
        check_req("rdr.drain", 1'b1, 32'h8);
        rst = 1'b1;
        tick();
        check_req("rdr.rst", 1'b0, 32'h0);
        check_slot("rdr.rst", 1'b0, 32'h0);
        rst = 1'b0; ack_en = 1'b1; settle();
        check_req("rdr.restart", 1'b1, 32'h0);
        tick();
        check_slot("rdr.first", 1'b1, 32'h0);
        check_req("rdr.next", 1'b1, 32'h4);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    // Watchdog so the bench always terminates
    initial begin
        #100000;
        $display("FAIL watchdog observed=timeout expected=finish");
        failures++;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $fatal(1, "watchdog expired");
    end

endmodule
`default_nettype wire

// File: doc/if_stage.md
Name: if_stage

Overview:
- Instruction-fetch stage of the MIPS pipeline. It owns the PC and issues fetches over a req/ack handshake to instruction memory.
- It holds the IF/ID pipeline register whose instruction bits [15:0] feed the decode-stage sign extender and register-file index fields.
- It handles hazard-unit stalls, branch/jump redirects and IF/ID flushes, and buffers one fetched word when decode is stalled.

Parameters:
- RESET_PC, 32'h0000_0000, PC value loaded on reset (word-aligned).
- NOP_WORD, 32'h0000_0000, instruction driven on ifid_instr_o when the slot is invalid (sll $0,$0,0).

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  synchronous reset, active-high.
- stall_i  in  1  hazard unit: hold IF/ID contents and PC.
- flush_i  in  1  squash IF/ID (taken branch/jump resolved downstream).
- redirect_i  in  1  load new PC (branch/jump target).
- redirect_pc_i  in  32  target PC, valid when redirect_i=1.
- imem_req_o  out  1  fetch request.
- imem_addr_o  out  32  fetch address, word-aligned.
- imem_ack_i  in  1  response valid; may assert in the same cycle as req (zero-wait).
- imem_rdata_i  in  32  instruction word, valid when ack=1.
- ifid_valid_o  out  1  IF/ID slot holds a real instruction.
- ifid_instr_o  out  32  instruction to decode (bits [15:0] go to sign extender).
- ifid_pc_o  out  32  PC of ifid_instr_o.
- ifid_pc4_o  out  32  ifid_pc_o + 4.

Behaviour:
- Reset state: pc=RESET_PC, state=FETCH, ifid_valid_o=0, ifid_instr_o=NOP_WORD, ifid_pc_o=0, ifid_pc4_o=0, skid buffer empty. imem_req_o=0 while rst=1.
- Priority in every cycle: rst > redirect_i/flush_i > stall_i.
- PC arithmetic is mod 2^32; pc+4 wraps 32'hFFFF_FFFC to 32'h0. Bits [1:0] of redirect_pc_i are forced to 0.
- Handshake: imem_req_o=1 in FETCH and DRAIN. imem_addr_o must be held stable from req assertion until the ack cycle. One outstanding request maximum.
- State FETCH (req=1, addr=pc):
  - On ack with redirect_i=1: discard the word, pc<=redirect_pc_i, stay FETCH.
  - On ack with stall_i=1: capture word+pc into the skid buffer, go to HOLD.
  - On ack otherwise: the word enters IF/ID this cycle, pc<=pc+4, stay FETCH. This gives back-to-back issue and 1 instruction/cycle with a zero-wait memory.
  - No ack with redirect_i=1: latch redirect_pc_i into pend_pc, go to DRAIN.
  - No ack otherwise: wait.
- State HOLD (req=0):
  - redirect_i=1: drop the buffer, pc<=redirect_pc_i, go to FETCH.
  - stall_i=0: the buffered word enters IF/ID, pc<=pc+4, go to FETCH.
  - Otherwise: hold.
- State DRAIN (req=1, addr=old pc):
  - On ack: discard the word, pc<=pend_pc, go to FETCH.
  - A further redirect_i in DRAIN overwrites pend_pc (latest wins).
- IF/ID register:
  - flush_i=1: valid<=0, instr<=NOP_WORD. This overrides stall_i and any arriving word.
  - stall_i=1 (no flush): hold all fields.
  - Otherwise, a word available this cycle (FETCH ack or HOLD release, no redirect): valid<=1, instr/pc/pc4 loaded.
  - Otherwise: bubble, valid<=0, instr<=NOP_WORD; pc/pc4 are don't-care but must be driven deterministically (hold).
- Simultaneous stall_i and redirect_i: redirect still updates the PC, and any in-flight or buffered fetch is discarded. IF/ID holds unless flush_i is asserted.
- Reset mid-request: the request is abandoned. Instruction memory shares rst and must drop it too; no ack is expected after reset.

Decomposition:
- Shared package cpu_pkg:
  - fetch state encoding (FETCH, HOLD, DRAIN)
  - NOP_WORD
  - PC_INC=32'd4
  - word-alignment mask
- One natural sub-module: if_id_reg. It holds the valid/instr/pc/pc4 flops with the flush>stall>load priority and is reused as a pattern for ID/EX.
- The PC/FSM logic stays in if_stage.

Test Plan:
- Reset release, zero-wait memory returning addr as data: req at 0x0, then 0x4, 0x8, ... each cycle. ifid_valid_o=1 from cycle 2, ifid_pc4_o=ifid_pc_o+4, no gaps.
- Memory with 3-cycle ack latency: addr 0x0 held stable 3 cycles. IF/ID shows bubbles (instr=0) until ack, then valid for 0x0.
- stall_i for 4 cycles while a fetch of 0x8 acks: IF/ID holds 0x4 and the word goes to HOLD with req=0. After stall drops, IF/ID=0x8 next edge and req resumes at 0xC.
- redirect_i to 0x100 with flush_i while the 0x10 request is pending: DRAIN until ack, 0x10 is discarded. Next req addr=0x100; IF/ID is invalid until 0x100 arrives.
- Stall + flush same cycle: IF/ID valid<=0. Also stall + redirect to 0x40 in HOLD: buffer dropped, next req at 0x40.
- PC wrap: redirect to 0xFFFF_FFFC, then the next fetch address is 0x0. Also rst asserted mid-DRAIN: req=0 next cycle, and after release the fetch restarts at RESET_PC.
